// File: rtl/ram_port_master.sv
// Generic FIFO: DEPTH entries, head word presented from storage registers.
// Latency: a push is visible at the head the cycle after the push edge.
// Backpressure: rd_vld until rd_rdy; pushes when full are dropped unless a pop frees a slot.
module sync_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_vld,
   input  logic [W-1:0] wr_dat,
   output logic         rd_vld,
   input  logic         rd_rdy,
   output logic [W-1:0] rd_dat
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wp_q, rp_q;
   logic [CW-1:0] cnt_q;
   logic          rd_en, wr_en;

   assign rd_vld = (cnt_q != '0);
   assign rd_dat = mem[rp_q];
   assign rd_en  = rd_vld & rd_rdy;
   assign wr_en  = wr_vld & ((cnt_q != FULL) | rd_en);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (wr_en) begin
            mem[wp_q] <= wr_dat;
            wp_q      <= (wp_q == LAST) ? '0 : wp_q + PW'(1);
         end
         if (rd_en)
            rp_q <= (rp_q == LAST) ? '0 : rp_q + PW'(1);
         case ({wr_en, rd_en})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end
endmodule

// RAM port initiator: valid/ready requests to RAM cycles, in-order read responses.
// Latency: accept to rsp_valid is RD_LATENCY+1 cycles minimum.
// Backpressure: reads are credit-limited to RESP_DEPTH, so rsp stalls never lose RAM data.
module ram_port_master #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int RD_LATENCY = 1,
   parameter int RESP_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout
);
   localparam int CW = $clog2(RESP_DEPTH + 1);
   localparam logic [CW-1:0] CREDIT_MAX = CW'(RESP_DEPTH);

   logic [CW-1:0]         credit_q;
   logic [RD_LATENCY-1:0] pipe_q, pipe_nxt;
   logic                  req_acc, rd_acc, rsp_pop, rd_ret;

   // Credits cover both in-flight reads and buffered responses.
   assign req_ready = ~rst & (credit_q < CREDIT_MAX);
   assign req_acc   = req_valid & req_ready;
   assign rd_acc    = req_acc & ~req_we;
   assign rsp_pop   = rsp_valid & rsp_ready;
   assign rd_ret    = pipe_q[RD_LATENCY-1];

   assign ram_en   = req_acc;
   assign ram_we   = req_we;
   assign ram_addr = req_addr;
   assign ram_din  = req_wdata;

   always_comb begin
      pipe_nxt    = pipe_q << 1;
      pipe_nxt[0] = rd_acc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_q   <= '0;
         credit_q <= '0;
      end else begin
         pipe_q <= pipe_nxt;
         case ({rd_acc, rsp_pop})
            2'b10:   credit_q <= credit_q + CW'(1);
            2'b01:   credit_q <= credit_q - CW'(1);
            default: credit_q <= credit_q;
         endcase
      end
   end

   // ram_dout is only guaranteed on the return edge; capture it there.
   sync_fifo #(
      .W     (DATA_WIDTH),
      .DEPTH (RESP_DEPTH)
   ) u_rsp_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_vld (rd_ret),
      .wr_dat (ram_dout),
      .rd_vld (rsp_valid),
      .rd_rdy (rsp_ready),
      .rd_dat (rsp_rdata)
   );
endmodule

// File: tb/tb_ram_port_master.sv
// Bench for ram_port_master: two instances (RD_LATENCY 1 and 2) share one request stream,
// each with its own RAM model and scoreboard.
module tb_ram_port_master;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we, rsp_ready;
   logic [9:0]  req_addr;
   logic [31:0] req_wdata;

   logic        a_req_ready, a_rsp_valid, a_ram_en, a_ram_we;
   logic [31:0] a_rsp_rdata, a_ram_din, a_ram_dout;
   logic [9:0]  a_ram_addr;
   logic        b_req_ready, b_rsp_valid, b_ram_en, b_ram_we;
   logic [31:0] b_rsp_rdata, b_ram_din, b_ram_dout;
   logic [9:0]  b_ram_addr;

   always #5 clk = ~clk;

   ram_port_master #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RD_LATENCY(1), .RESP_DEPTH(DEPTH)) u_dut_a (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(a_rsp_rdata), .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr),
      .ram_din(a_ram_din), .ram_dout(a_ram_dout));

   ram_port_master #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RD_LATENCY(2), .RESP_DEPTH(DEPTH)) u_dut_b (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(b_rsp_rdata), .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
      .ram_din(b_ram_din), .ram_dout(b_ram_dout));

   // RAM models: registered read, dout held while idle
   logic [31:0] mem_a [1024];
   logic [31:0] mem_b [1024];
   logic        b_rd_v = 1'b0;
   logic [31:0] b_rd_d;

   always @(posedge clk) begin
      if (a_ram_en) begin
         if (a_ram_we) mem_a[a_ram_addr] <= a_ram_din;
         else          a_ram_dout <= mem_a[a_ram_addr];
      end
   end

   always @(posedge clk) begin
      b_rd_v <= b_ram_en & ~b_ram_we;
      b_rd_d <= mem_b[b_ram_addr];
      if (b_ram_en & b_ram_we) mem_b[b_ram_addr] <= b_ram_din;
      if (b_rd_v) b_ram_dout <= b_rd_d;
   end

   // Reference model: shadow memory and expected-response ring per instance
   int          checks = 0;
   int          failures = 0;
   logic [31:0] model_mem [2][1024];
   logic [31:0] exp_buf [2][8];
   logic [31:0] pop_log [2][64];
   int          hd [2];
   int          outst [2];
   int          rsp_cnt [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic mon(input int id, input logic rr, input logic rv, input logic [31:0] rdata);
      string p;
      p = (id == 0) ? "a_" : "b_";
      if (rst) begin
         chk({p, "rst_req_ready"}, {31'b0, rr}, 32'd0);
         chk({p, "rst_rsp_valid"}, {31'b0, rv}, 32'd0);
         outst[id] = 0;
         hd[id]    = 0;
         return;
      end
      chk({p, "req_ready_credit"}, {31'b0, rr}, (outst[id] < DEPTH) ? 32'd1 : 32'd0);
      if (rv) begin
         if (outst[id] == 0) chk({p, "spurious_rsp"}, {31'b0, rv}, 32'd0);
         else                chk({p, "rsp_rdata"}, rdata, exp_buf[id][hd[id]]);
      end
      if (req_valid && rr) begin
         if (req_we) model_mem[id][req_addr] = req_wdata;
         else begin
            exp_buf[id][(hd[id] + outst[id]) % 8] = model_mem[id][req_addr];
            outst[id]++;
         end
      end
      if (rv && rsp_ready && outst[id] > 0) begin
         pop_log[id][rsp_cnt[id] % 64] = rdata;
         rsp_cnt[id]++;
         hd[id] = (hd[id] + 1) % 8;
         outst[id]--;
      end
      if (outst[id] > DEPTH) chk({p, "overflow"}, outst[id], DEPTH);
   endtask

   always @(negedge clk) begin
      mon(0, a_req_ready, a_rsp_valid, a_rsp_rdata);
      mon(1, b_req_ready, b_rsp_valid, b_rsp_rdata);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer_reads(input int n, input int base, input int max_cyc, output int acc);
      acc = 0;
      for (int c = 0; c < max_cyc && acc < n; c++) begin
         req_valid = 1'b1;
         req_we    = 1'b0;
         req_addr  = 10'(base + acc);
         @(negedge clk);
         if (a_req_ready) acc++;
         step();
      end
      req_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (outst[0] == 0 && outst[1] == 0) break;
         step();
      end
      chk({name, "_drained"}, outst[0] + outst[1], 32'd0);
   endtask

   typedef struct {
      logic        vld;
      logic        we;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic        exp_rr;
      logic        exp_rv;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t        vt [23];
   int          acc, base;
   logic [7:0]  t6_rv;

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem_a[i] = '0; mem_b[i] = '0;
         model_mem[0][i] = '0; model_mem[1][i] = '0;
      end
      a_ram_dout = '0; b_ram_dout = '0; b_rd_d = '0;
      for (int i = 0; i < 2; i++) begin hd[i] = 0; outst[i] = 0; rsp_cnt[i] = 0; end

      // Directed vectors: write/read 0x005, then 8 writes and 8 back-to-back reads
      for (int i = 0; i < 23; i++) vt[i] = '{1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 32'd0};
      vt[0] = '{1'b1, 1'b1, 10'h005, 32'hDEADBEEF, 1'b1, 1'b0, 32'd0};
      vt[1] = '{1'b1, 1'b0, 10'h005, 32'd0, 1'b1, 1'b0, 32'd0};
      vt[3].exp_rv = 1'b1; vt[3].exp_rdata = 32'hDEADBEEF;
      for (int i = 0; i < 8; i++) begin
         vt[4 + i]  = '{1'b1, 1'b1, 10'(i), 32'hA500_0000 + i, 1'b1, 1'b0, 32'd0};
         vt[12 + i] = '{1'b1, 1'b0, 10'(i), 32'd0, 1'b1, 1'b0, 32'd0};
      end
      for (int i = 0; i < 8; i++) begin
         vt[14 + i].exp_rv    = 1'b1;
         vt[14 + i].exp_rdata = 32'hA500_0000 + i;
      end

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
      @(negedge clk);
      chk("reset_req_ready", {31'b0, a_req_ready}, 32'd0);
      chk("reset_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
      chk("reset_rsp_rdata", a_rsp_rdata, 32'd0);
      step();
      rst = 1'b0;

      for (int i = 0; i < 23; i++) begin
         req_valid = vt[i].vld; req_we = vt[i].we; req_addr = vt[i].addr; req_wdata = vt[i].wdata;
         rsp_ready = 1'b1;
         @(negedge clk);
         chk($sformatf("vec%0d_req_ready", i), {31'b0, a_req_ready}, {31'b0, vt[i].exp_rr});
         chk($sformatf("vec%0d_rsp_valid", i), {31'b0, a_rsp_valid}, {31'b0, vt[i].exp_rv});
         if (vt[i].exp_rv) chk($sformatf("vec%0d_rsp_rdata", i), a_rsp_rdata, vt[i].exp_rdata);
         step();
      end
      drain("vec");

      // Credit limit under response backpressure
      rsp_ready = 1'b0;
      base = rsp_cnt[0];
      offer_reads(6, 0, 12, acc);
      chk("bp_accepted", acc, 32'd4);
      @(negedge clk);
      chk("bp_req_ready_low", {31'b0, a_req_ready}, 32'd0);
      step();
      rsp_ready = 1'b1;
      offer_reads(2, 4, 20, acc);
      chk("bp_rest_accepted", acc, 32'd2);
      drain("bp");
      chk("bp_rsp_count", rsp_cnt[0] - base, 32'd6);

      // Accept and pop in the same cycle at credit 3
      rsp_ready = 1'b0;
      offer_reads(3, 8, 10, acc);
      chk("c3_accepted", acc, 32'd3);
      repeat (4) step();
      req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd9; rsp_ready = 1'b1;
      @(negedge clk);
      chk("c3_rsp_valid", {31'b0, a_rsp_valid}, 32'd1);
      chk("c3_req_ready_pre", {31'b0, a_req_ready}, 32'd1);
      step();
      req_valid = 1'b0; rsp_ready = 1'b0;
      @(negedge clk);
      chk("c3_req_ready_same", {31'b0, a_req_ready}, 32'd1);
      step();
      req_valid = 1'b1; req_addr = 10'd10;
      @(negedge clk);
      chk("c3_req_ready_last", {31'b0, a_req_ready}, 32'd1);
      step();
      req_valid = 1'b0;
      @(negedge clk);
      chk("c3_req_ready_full", {31'b0, a_req_ready}, 32'd0);
      step();
      drain("c3");

      // Reset with reads in flight
      rsp_ready = 1'b0;
      offer_reads(2, 20, 6, acc);
      chk("rstmid_accepted", acc, 32'd2);
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("rstmid_req_ready", {31'b0, a_req_ready}, 32'd0);
         chk("rstmid_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
         step();
      end
      rst = 1'b0; rsp_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("rstmid_stale_rsp", {31'b0, a_rsp_valid}, 32'd0);
         step();
      end
      rsp_ready = 1'b0;
      offer_reads(5, 30, 10, acc);
      chk("rstmid_credit_zero", acc, 32'd4);
      drain("rstmid");

      // RD_LATENCY=2 instance: write A, read A, write A new, read A back-to-back
      base  = rsp_cnt[1];
      t6_rv = 8'b0101_0000;
      for (int s = 0; s < 8; s++) begin
         req_valid = (s < 4); req_addr = 10'h03C;
         req_we    = (s == 0 || s == 2);
         req_wdata = (s == 0) ? 32'h1111_1111 : 32'h2222_2222;
         @(negedge clk);
         chk($sformatf("l2_s%0d_req_ready", s), {31'b0, b_req_ready}, 32'd1);
         chk($sformatf("l2_s%0d_rsp_valid", s), {31'b0, b_rsp_valid}, {31'b0, t6_rv[s]});
         step();
      end
      drain("l2");
      chk("l2_rsp_count", rsp_cnt[1] - base, 32'd2);
      chk("l2_rsp_old", pop_log[1][base % 64], 32'h1111_1111);
      chk("l2_rsp_new", pop_log[1][(base + 1) % 64], 32'h2222_2222);

      // Randomized traffic against the scoreboards
      for (int c = 0; c < 3000; c++) begin
         req_valid = ($urandom_range(0, 3) != 0);
         req_we    = ($urandom_range(0, 2) == 0);
         req_addr  = 10'($urandom_range(0, 15));
         req_wdata = $urandom;
         rsp_ready = ((c % 200) < 40) ? 1'b0 : ($urandom_range(0, 3) != 0);
         step();
      end
      drain("rand");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
